// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 memory-side sequencer.
// Line geometry, FSM states, owner encoding and address helpers.
package cache_pkg;

  localparam int WPL    = 8;
  localparam int IDX_W  = $clog2(WPL);
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINE_W = WPL * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    DONE
  } state_e;

  typedef enum logic {
    OWN_DC,
    OWN_IC
  } owner_e;

  function automatic logic [ADDR_W-1:0] line_base(
    input logic [ADDR_W-1:0] addr
  );
    line_base = {addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_mem_sequencer_if.sv
// External 32-bit memory port: one beat per Req/Ack handshake.
// The sequencer is master; the memory model or controller is slave.
interface cache_mem_sequencer_if;
  import cache_pkg::*;

  logic              Mem_Req;
  logic              Mem_RW;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_WData;
  logic              Mem_Ack;
  logic [DATA_W-1:0] Mem_RData;

  modport master (
    output Mem_Req,
    output Mem_RW,
    output Mem_Addr,
    output Mem_WData,
    input  Mem_Ack,
    input  Mem_RData
  );

  modport slave (
    input  Mem_Req,
    input  Mem_RW,
    input  Mem_Addr,
    input  Mem_WData,
    output Mem_Ack,
    output Mem_RData
  );

endinterface

// File: rtl/mem_burst_counter.sv
// Beat counter for one line burst: word index = start + beats done,
// wrapping inside the line; flags the first and the last beat.
module mem_burst_counter
  import cache_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             adv_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [IDX_W-1:0] idx_nxt_o,
  output logic             first_o,
  output logic             last_o
);

  logic [IDX_W-1:0] start_q;
  logic [IDX_W-1:0] cnt_q;

  // Latch the start word at grant, then count acknowledged beats.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      start_q <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      start_q <= start_i;
      cnt_q   <= '0;
    end else if (adv_i) begin
      cnt_q   <= cnt_q + IDX_W'(1);
    end
  end

  assign idx_o     = start_q + cnt_q;
  assign idx_nxt_o = start_q + cnt_q + IDX_W'(1);
  assign first_o   = (cnt_q == '0);
  assign last_o    = (cnt_q == {IDX_W{1'b1}});

endmodule

// File: rtl/cache_mem_sequencer.sv
// Memory-side controller for the L1 caches: arbitrates DCache writebacks
// and D/I line fills onto one memory port as 8-beat critical-word bursts.
module cache_mem_sequencer
  import cache_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              DC_LW_Enable,
  input  logic [ADDR_W-1:0] DC_WB_Addr,
  input  logic [LINE_W-1:0] DC_LW_Data,
  output logic              DC_LW_Completed,
  input  logic              DC_LB_Enable,
  input  logic [ADDR_W-1:0] DC_MissAddr,
  output logic              DC_LB_Completed,
  output logic              DC_LB_FirstWord,
  input  logic              IC_LB_Enable,
  input  logic [ADDR_W-1:0] IC_MissAddr,
  output logic              IC_LB_Completed,
  output logic              IC_LB_FirstWord,
  output logic [LINE_W-1:0] LB_LineData,
  output logic [ADDR_W-1:0] LB_LineAddr,
  cache_mem_sequencer_if.master mem
);

  state_e                        state_q;
  owner_e                        own_q;
  owner_e                        rr_q;
  logic                          abort_q;
  logic [ADDR_W-IDX_W-1:0]       base_q;
  logic [WPL-1:0][DATA_W-1:0]    wb_q;
  logic [WPL-1:0][DATA_W-1:0]    lb_q;
  logic [ADDR_W-1:0]             lb_addr_q;
  logic                          req_q;
  logic                          rw_q;
  logic [ADDR_W-1:0]             addr_q;
  logic [DATA_W-1:0]             wdata_q;
  logic                          dc_lw_done_q;
  logic                          dc_lb_done_q;
  logic                          dc_fw_q;
  logic                          ic_lb_done_q;
  logic                          ic_fw_q;

  logic                          g_wb;
  logic                          g_dc;
  logic                          g_ic;
  logic                          load;
  logic [ADDR_W-1:0]             miss;
  logic [IDX_W-1:0]              start_idx;
  logic                          ack;
  logic                          adv;
  logic                          own_en;
  logic                          live;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              idx_nxt;
  logic                          first;
  logic                          last;
  logic [ADDR_W-1:0]             wb_base;

  // A stray Ack with no outstanding request must not move the burst.
  assign ack  = mem.Mem_Ack & req_q;
  assign adv  = ack & ((state_q == WB) | (state_q == FILL));
  assign live = own_en & ~abort_q;
  assign load = g_wb | g_dc | g_ic;

  assign wb_base = line_base(DC_WB_Addr);

  // Arbitration in IDLE: writeback first, then round-robin between fills.
  always_comb begin
    g_wb      = 1'b0;
    g_dc      = 1'b0;
    g_ic      = 1'b0;
    miss      = DC_MissAddr;
    start_idx = '0;
    if (state_q == IDLE) begin
      g_wb = DC_LW_Enable;
      g_dc = ~DC_LW_Enable & DC_LB_Enable &
             (~IC_LB_Enable | (rr_q == OWN_DC));
      g_ic = ~DC_LW_Enable & IC_LB_Enable &
             (~DC_LB_Enable | (rr_q == OWN_IC));
    end
    if (g_ic) begin
      miss = IC_MissAddr;
    end
    if (!g_wb) begin
      start_idx = miss[IDX_W-1:0];
    end
  end

  // The requester currently owning the port must keep its Enable high.
  always_comb begin
    own_en = 1'b0;
    unique case (state_q)
      WB:      own_en = DC_LW_Enable;
      FILL:    own_en = (own_q == OWN_DC) ? DC_LB_Enable
                                          : IC_LB_Enable;
      default: own_en = 1'b0;
    endcase
  end

  mem_burst_counter u_cnt (
    .Clk       (Clk),
    .Rst       (Rst),
    .load_i    (load),
    .start_i   (start_idx),
    .adv_i     (adv),
    .idx_o     (idx),
    .idx_nxt_o (idx_nxt),
    .first_o   (first),
    .last_o    (last)
  );

  // Sequencer FSM with registered memory-port and handshake outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      own_q        <= OWN_DC;
      rr_q         <= OWN_DC;
      abort_q      <= 1'b0;
      base_q       <= '0;
      wb_q         <= '0;
      lb_q         <= '0;
      lb_addr_q    <= '0;
      req_q        <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dc_lw_done_q <= 1'b0;
      dc_lb_done_q <= 1'b0;
      dc_fw_q      <= 1'b0;
      ic_lb_done_q <= 1'b0;
      ic_fw_q      <= 1'b0;
    end else begin
      dc_lw_done_q <= 1'b0;
      dc_lb_done_q <= 1'b0;
      dc_fw_q      <= 1'b0;
      ic_lb_done_q <= 1'b0;
      ic_fw_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (g_wb) begin
            state_q <= WB;
            own_q   <= OWN_DC;
            abort_q <= 1'b0;
            base_q  <= wb_base[ADDR_W-1:IDX_W];
            wb_q    <= DC_LW_Data;
            req_q   <= 1'b1;
            rw_q    <= 1'b1;
            addr_q  <= wb_base;
            wdata_q <= DC_LW_Data[DATA_W-1:0];
          end else if (g_dc || g_ic) begin
            state_q   <= FILL;
            own_q     <= g_dc ? OWN_DC : OWN_IC;
            rr_q      <= g_dc ? OWN_IC : OWN_DC;
            abort_q   <= 1'b0;
            base_q    <= miss[ADDR_W-1:IDX_W];
            lb_addr_q <= line_base(miss);
            req_q     <= 1'b1;
            rw_q      <= 1'b0;
            addr_q    <= miss;
            wdata_q   <= '0;
          end
        end
        WB, FILL: begin
          if (!own_en) begin
            abort_q <= 1'b1;
          end
          if (ack) begin
            if (state_q == FILL) begin
              lb_q[idx] <= mem.Mem_RData;
              if (first && live) begin
                if (own_q == OWN_DC) dc_fw_q <= 1'b1;
                else                 ic_fw_q <= 1'b1;
              end
            end
            if (last) begin
              state_q <= DONE;
              req_q   <= 1'b0;
              wdata_q <= '0;
              if (live) begin
                if (state_q == WB)        dc_lw_done_q <= 1'b1;
                else if (own_q == OWN_DC) dc_lb_done_q <= 1'b1;
                else                      ic_lb_done_q <= 1'b1;
              end
            end else begin
              addr_q  <= {base_q, idx_nxt};
              wdata_q <= (state_q == WB) ? wb_q[idx_nxt] : '0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign DC_LW_Completed = dc_lw_done_q;
  assign DC_LB_Completed = dc_lb_done_q;
  assign DC_LB_FirstWord = dc_fw_q;
  assign IC_LB_Completed = ic_lb_done_q;
  assign IC_LB_FirstWord = ic_fw_q;
  assign LB_LineData     = lb_q;
  assign LB_LineAddr     = lb_addr_q;

  assign mem.Mem_Req   = req_q;
  assign mem.Mem_RW    = rw_q;
  assign mem.Mem_Addr  = addr_q;
  assign mem.Mem_WData = wdata_q;

endmodule

// File: tb/tb_cache_mem_sequencer.sv
// Directed bench for cache_mem_sequencer: a memory responder checks every
// beat against a queue of expected beats; the main flow checks pulses/lines.
module tb_cache_mem_sequencer;
  import cache_pkg::*;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic         Clk;
  logic         Rst;
  logic         DC_LW_Enable;
  logic [31:0]  DC_WB_Addr;
  logic [255:0] DC_LW_Data;
  logic         DC_LW_Completed;
  logic         DC_LB_Enable;
  logic [31:0]  DC_MissAddr;
  logic         DC_LB_Completed;
  logic         DC_LB_FirstWord;
  logic         IC_LB_Enable;
  logic [31:0]  IC_MissAddr;
  logic         IC_LB_Completed;
  logic         IC_LB_FirstWord;
  logic [255:0] LB_LineData;
  logic [31:0]  LB_LineAddr;

  cache_mem_sequencer_if mif ();

  cache_mem_sequencer dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .DC_LW_Enable    (DC_LW_Enable),
    .DC_WB_Addr      (DC_WB_Addr),
    .DC_LW_Data      (DC_LW_Data),
    .DC_LW_Completed (DC_LW_Completed),
    .DC_LB_Enable    (DC_LB_Enable),
    .DC_MissAddr     (DC_MissAddr),
    .DC_LB_Completed (DC_LB_Completed),
    .DC_LB_FirstWord (DC_LB_FirstWord),
    .IC_LB_Enable    (IC_LB_Enable),
    .IC_MissAddr     (IC_MissAddr),
    .IC_LB_Completed (IC_LB_Completed),
    .IC_LB_FirstWord (IC_LB_FirstWord),
    .LB_LineData     (LB_LineData),
    .LB_LineAddr     (LB_LineAddr),
    .mem             (mif)
  );

  int    passes = 0;
  int    total  = 0;
  int    cyc    = 0;
  beat_t exp_q[$];
  int    stall_cfg = 0;
  int    stall_cnt = 0;
  logic  ack_idle  = 1'b0;
  int    n_dc_lb = 0;
  int    n_ic_lb = 0;
  int    n_lw    = 0;
  int    n_dc_fw = 0;
  int    n_ic_fw = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] o,
                     input logic [255:0] e);
    total = total + 1;
    assert (o === e) passes = passes + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    r = a * 32'h9E37_79B1;
    return r ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word(base + 32'(i));
    return l;
  endfunction

  task automatic push_fill(input logic [31:0] miss);
    logic [2:0] w;
    for (int k = 0; k < 8; k++) begin
      w = miss[2:0] + 3'(k);
      exp_q.push_back('{1'b0, {miss[31:3], w}, 32'h0});
    end
  endtask

  task automatic push_wb(input logic [31:0] a, input logic [255:0] d);
    for (int k = 0; k < 8; k++)
      exp_q.push_back('{1'b1, {a[31:3], 3'(k)}, d[k*32 +: 32]});
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return DC_LB_Completed;
      1:       return DC_LW_Completed;
      2:       return IC_LB_Completed;
      3:       return DC_LB_FirstWord;
      4:       return IC_LB_FirstWord;
      default: return DC_LB_Completed | IC_LB_Completed;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (sig(sel)) begin
        c = cyc;
        break;
      end
    end
  endtask

  // Memory responder: checks the request against the next expected beat
  // every cycle Req is high, stalls as configured, returns read data.
  initial begin
    beat_t e;
    mif.Mem_Ack   = 1'b0;
    mif.Mem_RData = '0;
    forever begin
      @(negedge Clk);
      n_dc_lb += int'(DC_LB_Completed);
      n_ic_lb += int'(IC_LB_Completed);
      n_lw    += int'(DC_LW_Completed);
      n_dc_fw += int'(DC_LB_FirstWord);
      n_ic_fw += int'(IC_LB_FirstWord);
      mif.Mem_RData = $urandom;
      if (!mif.Mem_Req) begin
        stall_cnt   = 0;
        mif.Mem_Ack = ack_idle;
      end else if (exp_q.size() == 0) begin
        chk("unexpected_beat", 256'(mif.Mem_Addr), 256'hDEAD);
        mif.Mem_Ack = 1'b1;
      end else begin
        e = exp_q[0];
        chk("beat_req",
            256'({mif.Mem_RW, mif.Mem_Addr,
                  mif.Mem_RW ? mif.Mem_WData : 32'h0}),
            256'({e.rw, e.addr, e.rw ? e.wdata : 32'h0}));
        if (stall_cnt < stall_cfg) begin
          mif.Mem_Ack = 1'b0;
          stall_cnt++;
        end else begin
          mif.Mem_Ack   = 1'b1;
          stall_cnt     = 0;
          mif.Mem_RData = mem_word(mif.Mem_Addr);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int t0;
    int c;
    int n0;
    int f0;
    logic [255:0] wb;
    logic [31:0] base;
    Rst          = 1'b1;
    DC_LW_Enable = 1'b0;
    DC_WB_Addr   = '0;
    DC_LW_Data   = '0;
    DC_LB_Enable = 1'b0;
    DC_MissAddr  = '0;
    IC_LB_Enable = 1'b0;
    IC_MissAddr  = '0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs",
        256'({DC_LW_Completed, DC_LB_Completed, DC_LB_FirstWord,
              IC_LB_Completed, IC_LB_FirstWord, LB_LineAddr,
              mif.Mem_Req, mif.Mem_RW, mif.Mem_Addr, mif.Mem_WData}),
        256'h0);
    chk("reset_line", LB_LineData, 256'h0);
    Rst = 1'b0;

    // 1: lone DC fill, Ack held high even while idle
    @(negedge Clk);
    ack_idle     = 1'b1;
    DC_MissAddr  = 32'h105;
    DC_LB_Enable = 1'b1;
    t0 = cyc;
    push_fill(32'h105);
    wait_sig(3, 20, c);
    chk("t1_fw_cycle", 256'(c - t0), 256'(2));
    wait_sig(0, 20, c);
    chk("t1_done_cycle", 256'(c - t0), 256'(9));
    DC_LB_Enable = 1'b0;
    chk("t1_line_addr", 256'(LB_LineAddr), 256'h100);
    chk("t1_line_data", LB_LineData, line_of(32'h100));
    chk("t1_beats_left", 256'(exp_q.size()), 256'(0));
    @(negedge Clk);
    ack_idle = 1'b0;

    // 2: writeback and fill raised together; victim drains first
    @(negedge Clk);
    for (int i = 0; i < 8; i++) wb[i*32 +: 32] = 32'hC0DE_0000 + 32'(i * 17);
    DC_WB_Addr   = 32'h200;
    DC_LW_Data   = wb;
    DC_LW_Enable = 1'b1;
    DC_MissAddr  = 32'h3F2;
    DC_LB_Enable = 1'b1;
    t0 = cyc;
    push_wb(32'h200, wb);
    push_fill(32'h3F2);
    @(negedge Clk);
    DC_LW_Data = ~wb;
    wait_sig(1, 20, c);
    chk("t2_wb_done_cycle", 256'(c - t0), 256'(9));
    DC_LW_Enable = 1'b0;
    wait_sig(0, 20, c);
    chk("t2_fill_done_cycle", 256'(c - t0), 256'(19));
    DC_LB_Enable = 1'b0;
    chk("t2_line_addr", 256'(LB_LineAddr), 256'h3F0);
    chk("t2_line_data", LB_LineData, line_of(32'h3F0));
    chk("t2_beats_left", 256'(exp_q.size()), 256'(0));

    // 3: both fills held; grants must alternate DC, IC, DC, IC
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst          = 1'b0;
    DC_MissAddr  = 32'h040;
    IC_MissAddr  = 32'h823;
    DC_LB_Enable = 1'b1;
    IC_LB_Enable = 1'b1;
    t0 = cyc;
    push_fill(32'h040);
    push_fill(32'h823);
    push_fill(32'h040);
    push_fill(32'h823);
    for (int r = 0; r < 4; r++) begin
      wait_sig(5, 40, c);
      chk("t3_done_cycle", 256'(c - t0), 256'(9 + 10 * r));
      chk("t3_owner", 256'({DC_LB_Completed, IC_LB_Completed}),
          (r % 2 == 0) ? 256'b10 : 256'b01);
      base = (r % 2 == 0) ? 32'h040 : 32'h820;
      chk("t3_line_data", LB_LineData, line_of(base));
      if (r % 2 == 0) DC_LB_Enable = 1'b0;
      else            IC_LB_Enable = 1'b0;
      if (r < 2) begin
        @(negedge Clk);
        if (r % 2 == 0) DC_LB_Enable = 1'b1;
        else            IC_LB_Enable = 1'b1;
      end
    end
    chk("t3_beats_left", 256'(exp_q.size()), 256'(0));

    // 4: three stall cycles before every Ack
    @(negedge Clk);
    stall_cfg = 3;
    for (int i = 0; i < 8; i++) wb[i*32 +: 32] = 32'h7700_0000 ^ 32'(i << 20);
    DC_WB_Addr   = 32'h5AF;
    DC_LW_Data   = wb;
    DC_LW_Enable = 1'b1;
    t0 = cyc;
    push_wb(32'h5AF, wb);
    wait_sig(1, 60, c);
    chk("t4_wb_done_cycle", 256'(c - t0), 256'(33));
    DC_LW_Enable = 1'b0;
    @(negedge Clk);
    IC_MissAddr  = 32'h0C3;
    IC_LB_Enable = 1'b1;
    t0 = cyc;
    push_fill(32'h0C3);
    wait_sig(4, 60, c);
    chk("t4_fw_cycle", 256'(c - t0), 256'(5));
    wait_sig(2, 60, c);
    chk("t4_fill_done_cycle", 256'(c - t0), 256'(33));
    IC_LB_Enable = 1'b0;
    chk("t4_line_data", LB_LineData, line_of(32'h0C0));
    @(negedge Clk);
    stall_cfg = 0;

    // 5: reset during beat 4 of an IC fill, then a fresh request
    @(negedge Clk);
    IC_MissAddr  = 32'h777;
    IC_LB_Enable = 1'b1;
    t0 = cyc;
    push_fill(32'h777);
    repeat (5) @(negedge Clk);
    Rst          = 1'b1;
    IC_LB_Enable = 1'b0;
    @(negedge Clk);
    chk("t5_reset_outputs",
        256'({DC_LW_Completed, DC_LB_Completed, DC_LB_FirstWord,
              IC_LB_Completed, IC_LB_FirstWord, LB_LineAddr,
              mif.Mem_Req, mif.Mem_RW, mif.Mem_Addr, mif.Mem_WData}),
        256'h0);
    chk("t5_reset_line", LB_LineData, 256'h0);
    Rst = 1'b0;
    exp_q.delete();
    IC_MissAddr  = 32'h77A;
    IC_LB_Enable = 1'b1;
    t0 = cyc;
    push_fill(32'h77A);
    wait_sig(4, 20, c);
    chk("t5_fw_cycle", 256'(c - t0), 256'(2));
    wait_sig(2, 20, c);
    chk("t5_done_cycle", 256'(c - t0), 256'(9));
    IC_LB_Enable = 1'b0;
    chk("t5_line_addr", 256'(LB_LineAddr), 256'h778);
    chk("t5_line_data", LB_LineData, line_of(32'h778));

    // 6: IC drops Enable at beat 2 with a DC fill pending
    @(negedge Clk);
    n0 = n_ic_lb;
    f0 = n_ic_fw;
    IC_MissAddr  = 32'h9C6;
    IC_LB_Enable = 1'b1;
    t0 = cyc;
    push_fill(32'h9C6);
    @(negedge Clk);
    DC_MissAddr  = 32'h311;
    DC_LB_Enable = 1'b1;
    push_fill(32'h311);
    repeat (2) @(negedge Clk);
    IC_LB_Enable = 1'b0;
    wait_sig(0, 40, c);
    chk("t6_dc_done_cycle", 256'(c - t0), 256'(19));
    DC_LB_Enable = 1'b0;
    chk("t6_ic_no_completed", 256'(n_ic_lb - n0), 256'(0));
    chk("t6_ic_fw_once", 256'(n_ic_fw - f0), 256'(1));
    chk("t6_line_data", LB_LineData, line_of(32'h310));
    chk("t6_beats_left", 256'(exp_q.size()), 256'(0));

    repeat (3) @(negedge Clk);
    chk("end_idle", 256'(mif.Mem_Req), 256'(0));
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
